// File: rtl/phase2_pkg.sv
// rtl/phase2_pkg.sv - shared constants and types for phase2 and its sequencer
package phase2_pkg;

    localparam int DW = 8;
    localparam int N  = 8;
    localparam int VW = N * DW;

    typedef logic [VW-1:0] vec_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_RUN,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/phase2_ctrl.sv
// rtl/phase2_ctrl.sv - column sequencer for phase2 (optional abort: PHASE2_CTRL_ABORT_EN)
module phase2_ctrl #(
    parameter int DW     = phase2_pkg::DW,
    parameter int N      = phase2_pkg::N,
    parameter int N_COLS = 8,
    parameter int LAT    = 2,
    parameter int AW     = $clog2(N_COLS)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [N*DW-1:0]   h_in,
    input  logic [N*DW-1:0]   y_in,
`ifdef PHASE2_CTRL_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic              col_rd,
    output logic [AW-1:0]     col_addr,
    input  logic [N*DW-1:0]   col_rdata,
    output logic              dp_enable,
    output logic [N*DW-1:0]   dp_x_col,
    output logic [N*DW-1:0]   dp_h,
    output logic [N*DW-1:0]   dp_y,
    input  logic [N*DW-1:0]   dp_g,
    output logic              res_we,
    output logic [AW-1:0]     res_addr,
    output logic [N*DW-1:0]   res_wdata
);

    import phase2_pkg::*;

    localparam int VW = N * DW;
    localparam int CW = $clog2(LAT + 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [AW-1:0]   r_idx;
    logic [CW-1:0]   r_cnt;
    logic [VW-1:0]   r_dp_h;
    logic [VW-1:0]   r_dp_y;
    logic [VW-1:0]   r_x_col;
    logic [VW-1:0]   r_res_wdata;
    logic            w_last;
    logic            w_abort;

`ifdef PHASE2_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_last    = (r_idx == AW'(N_COLS - 1));
    assign col_addr  = r_idx;
    assign res_addr  = r_idx;
    assign dp_h      = r_dp_h;
    assign dp_y      = r_dp_y;
    assign dp_x_col  = r_x_col;
    assign res_wdata = r_res_wdata;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and strobes decoded from the current state; abort overrides everything
    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != S_IDLE);
        col_rd       = 1'b0;
        dp_enable    = 1'b0;
        res_we       = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                col_rd       = 1'b1;
                w_next_state = S_LOAD;
            end
            S_LOAD: begin
                w_next_state = S_RUN;
            end
            S_RUN: begin
                dp_enable = 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                res_we       = 1'b1;
                w_next_state = w_last ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (w_abort && (r_state != S_IDLE)) begin
            w_next_state = S_IDLE;
        end
    end

    // Operand latches, column index and latency down-counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_idx       <= '0;
            r_cnt       <= '0;
            r_dp_h      <= '0;
            r_dp_y      <= '0;
            r_x_col     <= '0;
            r_res_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dp_h <= h_in;
                        r_dp_y <= y_in;
                        r_idx  <= '0;
                    end
                end
                S_LOAD: begin
                    r_x_col <= col_rdata;
                    r_cnt   <= CW'(LAT);
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_res_wdata <= dp_g;
                    end
                end
                S_WRITE: begin
                    if (!w_last && !w_abort) begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase2_ctrl.sv
// tb/tb_phase2_ctrl.sv - randomized self-checking bench for phase2_ctrl
module tb_phase2_ctrl;

    parameter int LAT = 2;

    localparam int DW      = 8;
    localparam int N       = 8;
    localparam int VW      = N * DW;
    localparam int N_COLS  = 8;
    localparam int AW      = $clog2(N_COLS);
    localparam int RUN_CYC = 1 + N_COLS * (LAT + 3);

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            start = 1'b0;
    logic [VW-1:0]   h_in = '0;
    logic [VW-1:0]   y_in = '0;
    logic            abort = 1'b0;
    logic            busy, done, col_rd, dp_enable, res_we;
    logic [AW-1:0]   col_addr, res_addr;
    logic [VW-1:0]   col_rdata = '0;
    logic [VW-1:0]   dp_x_col, dp_h, dp_y, dp_g, res_wdata;
    logic [VW-1:0]   junk = '0;

    phase2_ctrl #(.DW(DW), .N(N), .N_COLS(N_COLS), .LAT(LAT), .AW(AW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .h_in(h_in), .y_in(y_in),
`ifdef PHASE2_CTRL_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .col_rd(col_rd), .col_addr(col_addr),
        .col_rdata(col_rdata), .dp_enable(dp_enable), .dp_x_col(dp_x_col),
        .dp_h(dp_h), .dp_y(dp_y), .dp_g(dp_g), .res_we(res_we),
        .res_addr(res_addr), .res_wdata(res_wdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // phase2 reference: g[e] = (h[e] - y[e]) * x[e], truncated to DW bits
    function automatic logic [VW-1:0] g_ref(input logic [VW-1:0] x, h, y);
        logic [VW-1:0] r;
        logic [DW-1:0] d;
        r = '0;
        for (int e = 0; e < N; e++) begin
            d = h[e*DW +: DW] - y[e*DW +: DW];
            r[e*DW +: DW] = DW'(d * x[e*DW +: DW]);
        end
        return r;
    endfunction

    logic [VW-1:0] mem [N_COLS];
    logic [VW-1:0] exp_h, exp_y, run_h;

    // Datapath and column-memory stand-ins; junk outside valid windows exposes bad sampling
    assign dp_g = dp_enable ? g_ref(dp_x_col, dp_h, dp_y) : junk;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        junk  <= {$urandom, $urandom};
        col_rdata <= col_rd ? mem[col_addr] : {$urandom, $urandom};
    end

    // Monitor: collect writes and per-run event counts
    logic [AW-1:0] wr_addr [$];
    logic [VW-1:0] wr_data [$];
    logic [VW-1:0] wr_x    [$];
    int n_done, n_en, n_excl, n_hchg, n_addr_bad;

    always @(negedge clk) begin
        if (res_we) begin
            wr_addr.push_back(res_addr);
            wr_data.push_back(res_wdata);
            wr_x.push_back(dp_x_col);
        end
        if (done) n_done++;
        if (dp_enable) n_en++;
        if ((int'(col_rd) + int'(dp_enable) + int'(res_we)) > 1) n_excl++;
        if (busy && (dp_h !== run_h)) n_hchg++;
        if (col_rd && (int'(col_addr) > N_COLS - 1)) n_addr_bad++;
    end

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        wr_x.delete();
        n_done = 0; n_en = 0; n_excl = 0; n_hchg = 0; n_addr_bad = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 2 * RUN_CYC + 20; i++) begin
            if (done) begin
                ok = 1'b1;
                t  = cyc;
                return;
            end
            tick();
        end
    endtask

    task automatic fill_mem(input bit nominal);
        for (int i = 0; i < N_COLS; i++)
            mem[i] = nominal ? {N{8'(8'h9C + i)}} : {$urandom, $urandom};
    endtask

    task automatic verify_writes(input string tag, input int n);
        chk({tag, ":n_writes"}, wr_addr.size(), n);
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            chk($sformatf("%s:addr%0d", tag, i), wr_addr[i], i);
            chk($sformatf("%s:x%0d", tag, i), wr_x[i], mem[i]);
            chk($sformatf("%s:g%0d", tag, i), wr_data[i], g_ref(mem[i], exp_h, exp_y));
        end
    endtask

    task automatic begin_run(input logic [VW-1:0] h, y, output int t0);
        clear_mon();
        exp_h = h; exp_y = y; run_h = h;
        tick();
        start = 1'b1; h_in = h; y_in = y; t0 = cyc;
        tick();
        start = 1'b0; h_in = {$urandom, $urandom}; y_in = {$urandom, $urandom};
    endtask

    // Full run; optionally poke start during FETCH of column poke_col and/or in the DONE cycle
    task automatic do_run(input string tag, input logic [VW-1:0] h, y,
                          input int poke_col, input bit poke_done);
        int t0, td;
        bit ok;
        begin_run(h, y, t0);
        if (poke_col >= 0) begin
            ok = 1'b0;
            for (int i = 0; i < RUN_CYC && !ok; i++) begin
                if (col_rd && (int'(col_addr) == poke_col)) ok = 1'b1;
                else tick();
            end
            chk({tag, ":poke_found"}, ok, 1'b1);
            start = 1'b1; h_in = '1;
            tick();
            start = 1'b0;
            chk({tag, ":dp_h_held"}, dp_h, h);
        end
        wait_done(td, ok);
        chk({tag, ":done_lat"}, ok ? VW'(td - t0) : '1, RUN_CYC);
        if (poke_done) begin
            start = 1'b1; h_in = '1; y_in = '0;
            tick();
            start = 1'b0;
            chk({tag, ":start_at_done_ignored"}, busy, 1'b0);
            tick();
            chk({tag, ":still_idle"}, busy, 1'b0);
        end else begin
            tick();
        end
        verify_writes(tag, N_COLS);
        chk({tag, ":en_cycles"}, n_en, N_COLS * LAT);
        chk({tag, ":n_done"}, n_done, 1);
        chk({tag, ":excl"}, n_excl, 0);
        chk({tag, ":h_stable"}, n_hchg, 0);
        chk({tag, ":addr_range"}, n_addr_bad, 0);
        chk({tag, ":busy_end"}, busy, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ":busy"}, busy, 1'b0);
        chk({tag, ":strobes"}, {done, col_rd, dp_enable, res_we}, 4'b0);
        chk({tag, ":addrs"}, {col_addr, res_addr}, '0);
        chk({tag, ":dp_h"}, dp_h, '0);
        chk({tag, ":dp_y"}, dp_y, '0);
        chk({tag, ":dp_x_col"}, dp_x_col, '0);
        chk({tag, ":res_wdata"}, res_wdata, '0);
    endtask

    initial begin
        int t0;
        bit ok;
        run_h = '0;
        clear_mon();
        fill_mem(1'b1);

        // Reset state
        repeat (3) tick();
        chk_all_zero("reset");
        resetn = 1'b1;
        repeat (5) tick();
        chk("idle_busy", busy, 1'b0);
        chk("idle_strobes", n_en + n_done + wr_addr.size(), 0);

        // Nominal run plus start in the DONE cycle
        do_run("nominal", {N{8'h5E}}, {N{8'h44}}, -1, 1'b1);

        // Start while busy during FETCH of column 3
        do_run("busy_start", {N{8'h5E}}, {N{8'h44}}, 3, 1'b0);

        // Randomized runs
        for (int r = 0; r < 4; r++) begin
            fill_mem(1'b0);
            do_run($sformatf("rand%0d", r), {$urandom, $urandom}, {$urandom, $urandom},
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N_COLS - 1)) : -1,
                   1'($urandom_range(0, 1)));
        end

        // Reset during RUN of column 2
        fill_mem(1'b1);
        begin_run({N{8'h5E}}, {N{8'h44}}, t0);
        ok = 1'b0;
        for (int i = 0; i < RUN_CYC && !ok; i++) begin
            if (dp_enable && wr_addr.size() == 2) ok = 1'b1;
            else tick();
        end
        chk("midrst:found_run2", ok, 1'b1);
        resetn = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick();
        resetn = 1'b1;
        run_h = '0;
        repeat (3) tick();
        chk("midrst:n_writes", wr_addr.size(), 2);
        chk("midrst:no_done", n_done, 0);
        chk("midrst:idle", busy, 1'b0);
        do_run("after_rst", {N{8'h5E}}, {N{8'h44}}, -1, 1'b0);

`ifdef PHASE2_CTRL_ABORT_EN
        // Abort during WRITE of column 4
        begin_run({N{8'h5E}}, {N{8'h44}}, t0);
        ok = 1'b0;
        for (int i = 0; i < RUN_CYC && !ok; i++) begin
            if (res_we && int'(res_addr) == 4) ok = 1'b1;
            else tick();
        end
        chk("abort:found_wr4", ok, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort:busy", busy, 1'b0);
        chk("abort:strobes", {col_rd, dp_enable, res_we, done}, 4'b0);
        repeat (4) tick();
        chk("abort:n_writes", wr_addr.size(), 5);
        chk("abort:no_done", n_done, 0);
        do_run("after_abort", {N{8'h5E}}, {N{8'h44}}, -1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
